serial_vec_rx: RTL and testbench
================================

# serial_vec_rx

- Receives stimulus vectors as framed serial bits and presents each one as a parallel word with a valid/ready handshake.
- It is the receive end of the serial stimulus link; a companion serializer drives the link.
- Its output feeds gate-level primitive netlists under test, for example the a/b/c inputs of a three-input AND/OR structure.
- Framing is a start marker, WIDTH data bits sent LSB first, and one even-parity bit. Bad frames are dropped and counted.

## Interface

Parameters:
- WIDTH, default 3: data bits per frame; WIDTH >= 1.
- ERR_W, default 8: width of the frame-error counter.

Ports:
- clk, input, 1: single clock; everything samples on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sin, input, 1: serial data bit.
- sin_valid, input, 1: sin carries a bit this cycle.
- sin_ready, output, 1: block can accept a bit this cycle.
- vec, output, WIDTH: last correctly received vector.
- vec_valid, output, 1: vec holds an unconsumed vector.
- vec_ready, input, 1: consumer accepts vec.
- frame_err, output, 1: one-cycle pulse on a parity failure.
- err_cnt, output, ERR_W: saturating count of parity failures.

## Operation

- A bit is accepted on a rising edge where sin_valid && sin_ready. All state changes below happen only on accepted bits, except in HOLD.
- sin_ready is 1 in every state except HOLD (combinational from state).
- IDLE
  - Accepted sin=0 is idle filler and is ignored.
  - Accepted sin=1 is the start marker: clear the shift register and bit_cnt, go to DATA.
- DATA
  - Accepted bit is written to shift[bit_cnt], then bit_cnt increments.
  - After bit WIDTH-1 is accepted, go to PARITY.
  - bit_cnt width is max(1, $clog2(WIDTH)) and never exceeds WIDTH-1.
- PARITY: the accepted bit p is checked against the data.
  - Good frame, when ^shift ^ p == 0: load vec <= shift, set vec_valid, go to HOLD.
  - Bad frame, otherwise: pulse frame_err for one cycle, increment err_cnt (saturating at all-ones), leave vec unchanged, go to IDLE.
- HOLD
  - vec_valid=1; vec is stable.
  - On an edge with vec_ready=1: clear vec_valid, go to IDLE.
  - sin_valid in HOLD is ignored because sin_ready=0; the sender must stall.
- vec keeps its last good value after the handshake and after bad frames.
- vec_ready while vec_valid=0 has no effect.
- States: IDLE, DATA, PARITY, HOLD. Encoding is free; no other reachable states.

## Timing

- Reset values (asynchronous, while rst_n=0): state=IDLE, vec=0, vec_valid=0, frame_err=0, err_cnt=0, bit_cnt=0, shift=0, sin_ready=1.
- Reset asserted mid-frame or in HOLD discards everything immediately. The first edge after release behaves as IDLE.
- Latency: vec_valid rises on the same edge that accepts the parity bit, visible the following cycle.
- frame_err is high exactly in the cycle after the bad parity bit is accepted.
- Minimum frame period is WIDTH+3 cycles: start, WIDTH data, parity, and at least one HOLD cycle.
  - Handshake edge: vec_valid falls and sin_ready rises in the next cycle.
  - A new start marker is accepted no earlier than the cycle after the handshake edge.
- Gaps (sin_valid=0) are allowed anywhere in a frame; the frame has no timeout.
- err_cnt holds at 2^ERR_W-1 on further errors; frame_err still pulses.

## Test plan

- Reset and idle: assert rst_n=0 mid-DATA, release, then send sin=0 filler for 5 cycles.
  - Required: vec=0, vec_valid=0, sin_ready=1 throughout, no frame_err.
- Good frame, WIDTH=3: send 1,1,0,1,0 (start, bits LSB-first 1,0,1, parity 0) with vec_ready=1.
  - Required: vec=3'b101 and vec_valid=1 one cycle after the parity bit; vec_valid=0 the cycle after that.
- Back-pressure: same frame with vec_ready=0 for 4 cycles while the sender holds sin_valid=1, sin=1.
  - Required: sin_ready=0 and vec=3'b101 stable all 4 cycles.
  - Required: after vec_ready=1, the next start marker is accepted the cycle after the handshake.
- Parity error: send 1,1,1,0,1 (data 3'b011, parity 1).
  - Required: frame_err=1 for exactly 1 cycle, err_cnt=1, vec still at its previous value 3'b101, vec_valid=0.
- Gapped frame: send 1,0,1,1,0 (data 3'b110, parity 0) with sin_valid=0 for 2 cycles between every bit.
  - Required: vec=3'b110 and vec_valid=1.
- Saturation, ERR_W=2: send 5 bad frames.
  - Required: err_cnt goes 1,2,3,3,3; frame_err pulses 5 times.

Source files
------------

// File: rtl/serial_vec_rx.sv
// rtl/serial_vec_rx.sv - framed serial-to-parallel stimulus receiver with even parity
// Frame: start marker (1), WIDTH data bits LSB first, even-parity bit; bad frames dropped and counted.
module serial_vec_rx #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] vec,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept;

  assign sin_ready = (state_q != S_HOLD);
  assign accept    = sin_valid && sin_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Accepted zeros are line filler; only a one opens a frame.
        if (accept && sin) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d[bit_cnt_q] = sin;
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (accept) begin
          if ((^shift_q ^ sin) == 1'b0) begin
            vec_d       = shift_q;
            vec_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            frame_err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            state_d = S_IDLE;
          end
        end
      end

      S_HOLD: begin
        // The sender is stalled by sin_ready=0 until the consumer takes vec.
        if (vec_ready) begin
          vec_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_serial_vec_rx.sv
// tb/tb_serial_vec_rx.sv - scoreboard bench for serial_vec_rx (WIDTH=3, ERR_W=8 and ERR_W=2)
module tb_serial_vec_rx;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       vec_ready;

  logic       sin_ready;
  logic [2:0] vec;
  logic       vec_valid;
  logic       frame_err;
  logic [7:0] err_cnt;

  logic       sin_ready2;
  logic [2:0] vec2;
  logic       vec_valid2;
  logic       frame_err2;
  logic [1:0] err_cnt2;

  int total;
  int bad;

  logic [2:0] exp_q[$];
  logic [2:0] last_good;
  int         err_model;
  int         pulse_cnt;

  serial_vec_rx #(.WIDTH(3), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready),
    .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  serial_vec_rx #(.WIDTH(3), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready2),
    .vec(vec2), .vec_valid(vec_valid2), .vec_ready(vec_ready),
    .frame_err(frame_err2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    sin_valid = 1'b0;
    repeat (gap) step();
    sin       = b;
    sin_valid = 1'b1;
    step();
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  // Sends a full frame; the final parity bit's edge has just been sampled on return.
  task automatic send_frame(input logic [2:0] data, input logic corrupt, input int gap);
    logic p;
    p = (^data) ^ corrupt;
    send_bit(1'b1, gap);
    for (int i = 0; i < 3; i++) send_bit(data[i], gap);
    if (!corrupt) exp_q.push_back(data);
    send_bit(p, gap);
  endtask

  task automatic check_good_out(input string name);
    logic [2:0] e;
    total++;
    if (vec_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s vec_valid got=%0b exp=1", name, vec_valid);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected vector got=%0b", name, vec);
    end else begin
      e = exp_q.pop_front();
      last_good = e;
      total++;
      if (vec !== e) begin
        bad++;
        $display("FAIL %s vec got=%b exp=%b", name, vec, e);
      end
    end
  endtask

  task automatic check_bad_out(input string name);
    err_model = (err_model < 255) ? err_model + 1 : 255;
    total++;
    if (frame_err !== 1'b1) begin
      bad++;
      $display("FAIL %s frame_err got=%0b exp=1", name, frame_err);
    end
    total++;
    if (err_cnt !== err_model[7:0]) begin
      bad++;
      $display("FAIL %s err_cnt got=%0d exp=%0d", name, err_cnt, err_model);
    end
    total++;
    if (vec !== last_good || vec_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s vec/vec_valid got=%b/%0b exp=%b/0", name, vec, vec_valid, last_good);
    end
    step();
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s frame_err_width got=%0b exp=0", name, frame_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    total++;
    if (vec !== 3'b000 || vec_valid !== 1'b0 || sin_ready !== 1'b1 ||
        frame_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_values got vec=%b vv=%0b rdy=%0b fe=%0b ec=%0d exp 000/0/1/0/0",
               vec, vec_valid, sin_ready, frame_err, err_cnt);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 0);
      total++;
      if (vec !== 3'b000 || vec_valid !== 1'b0 || sin_ready !== 1'b1 || frame_err !== 1'b0) begin
        bad++;
        $display("FAIL idle_filler[%0d] got vec=%b vv=%0b rdy=%0b fe=%0b exp 000/0/1/0",
                 i, vec, vec_valid, sin_ready, frame_err);
      end
    end
    last_good = 3'b000;
    err_model = 0;
  endtask

  task automatic test_good_frame();
    vec_ready = 1'b1;
    send_frame(3'b101, 1'b0, 0);
    check_good_out("good_frame");
    step();
    total++;
    if (vec_valid !== 1'b0 || sin_ready !== 1'b1 || vec !== 3'b101) begin
      bad++;
      $display("FAIL good_handshake got vv=%0b rdy=%0b vec=%b exp 0/1/101", vec_valid, sin_ready, vec);
    end
  endtask

  task automatic test_parity_error();
    vec_ready = 1'b1;
    send_frame(3'b011, 1'b1, 0);
    check_bad_out("parity_err");
  endtask

  task automatic test_back_pressure();
    vec_ready = 1'b0;
    send_frame(3'b101, 1'b0, 0);
    check_good_out("bp_frame");
    sin       = 1'b1;
    sin_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (sin_ready !== 1'b0 || vec !== 3'b101 || vec_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d] got rdy=%0b vec=%b vv=%0b exp 0/101/1", i, sin_ready, vec, vec_valid);
      end
    end
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    total++;
    if (vec_valid !== 1'b0 || sin_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got vv=%0b rdy=%0b exp 0/1", vec_valid, sin_ready);
    end
    // sin=1 still held: this edge must take it as the next start marker.
    step();
    sin_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(i == 1, 0);
    exp_q.push_back(3'b010);
    send_bit(1'b1, 0);
    check_good_out("bp_next_start");
    vec_ready = 1'b1;
    step();
  endtask

  task automatic test_gapped_frame();
    vec_ready = 1'b0;
    send_frame(3'b110, 1'b0, 2);
    check_good_out("gapped");
    vec_ready = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int exp2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    err_model = 0;
    last_good = 3'b000;
    pulse_cnt = 0;
    vec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_frame(3'($urandom_range(0, 7)), 1'b1, i % 2);
      exp2 = (i + 1 > 3) ? 3 : i + 1;
      if (frame_err2 === 1'b1) pulse_cnt++;
      total++;
      if (err_cnt2 !== exp2[1:0]) begin
        bad++;
        $display("FAIL sat_err_cnt[%0d] got=%0d exp=%0d", i, err_cnt2, exp2);
      end
      check_bad_out("sat_wide");
    end
    total++;
    if (pulse_cnt != 5) begin
      bad++;
      $display("FAIL sat_pulses got=%0d exp=5", pulse_cnt);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    vec_ready = 1'b0;
    last_good = 3'b000;
    err_model = 0;
    pulse_cnt = 0;

    test_reset();
    test_good_frame();
    test_parity_error();
    test_back_pressure();
    test_gapped_frame();
    test_saturation();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
